seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_BITS, default 17: slot length is 2^SCAN_BITS clock cycles.
REQ-002 Parameter BLANK_CYCLES, default 1024: anode-off guard cycles at the start of each slot; legal range 1 to 2^SCAN_BITS-1.
REQ-003 clock  input  1  system clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  scan enable; low forces IDLE.
REQ-006 digits  input  16  four hex nibbles; digit i is digits[4i+3:4i].
REQ-007 dp_mask  input  4  decimal point request per digit, active-high.
REQ-008 digit_en  input  4  per-digit display enable, active-high.
REQ-009 an  output  4  digit anodes, active-low, registered.
REQ-010 seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 dp  output  1  decimal point, active-low, registered.
REQ-012 frame_start  output  1  one-cycle pulse at the start of digit 0's slot.

Function
REQ-013 Shall contain one SCAN_BITS-wide slot counter cnt, a 2-bit digit index idx, and FSM states IDLE, BLANK and SHOW.
REQ-014 IDLE: an=4'b1111, seg=7'h7F, dp=1, cnt=0, idx=0; enable high moves the FSM to BLANK on the next cycle.
REQ-015 BLANK: an=4'b1111; cnt increments each cycle; at cnt==BLANK_CYCLES-1 the FSM moves to SHOW.
REQ-016 SHOW: an[idx]=0 only if digit_en[idx]=1, all other anodes 1; cnt increments; at cnt==2^SCAN_BITS-1, cnt wraps to 0, idx advances (3 wraps to 0), and the FSM moves to BLANK.
REQ-017 Slot length shall be exactly 2^SCAN_BITS cycles; a frame shall be 4 slots.
REQ-018 Disabled digits (digit_en[idx]=0) shall still consume their slot with the anode off, so the refresh rate is constant.
REQ-019 digits, dp_mask and digit_en shall be captured into a holding register on every entry into BLANK; SHOW output shall use only the captured values.
REQ-020 seg shall be the hex decode of the captured nibble[idx]; dp=~dp_mask[idx] during SHOW, otherwise 1.
REQ-021 frame_start shall be 1 for exactly the first cycle of each BLANK with idx=0, including the first slot after leaving IDLE.
REQ-022 enable low in any state shall force IDLE on the next edge, clear cnt and idx, and drive anodes off; an in-progress slot is abandoned.
REQ-023 All outputs shall be registered, with no combinational path from any input to any output.

Reset
REQ-024 reset=1 shall immediately force state IDLE, cnt=0, idx=0, an=4'b1111, seg=7'h7F, dp=1, frame_start=0, and a zero holding register.
REQ-025 Reset deassertion with enable high shall start the scan exactly as an IDLE exit does (REQ-014).

Configuration
REQ-026 Macro SEG_LEADING_ZERO_BLANK_EN, when defined: for idx>0, if the captured nibble[idx] and all higher nibbles are 0, then seg=7'h7F; the anode behaves as in REQ-016, and digit 0 is never blanked.
REQ-027 Without SEG_LEADING_ZERO_BLANK_EN, every nibble shall be decoded normally.

Structure
REQ-028 Package seg_pkg shall hold the FSM state enum and the 16-entry active-low segment constant table (0=7'b1000000, 1=7'b1111001, F=7'b0001110, ...).
REQ-029 Sub-module seg_hex_decode (purely combinational, nibble in, seg out, table from seg_pkg) shall be instantiated once.

Verification (SCAN_BITS=4, BLANK_CYCLES=2)
REQ-030 Reset mid-SHOW: assert reset -> an=1111 and seg=7F without a clock edge; after release with enable=1, frame_start pulses on the first BLANK cycle.
REQ-031 digits=16'h12AF, digit_en=1111, dp_mask=0001 -> slot 0: 2 cycles with an=1111, then 14 cycles with an=1110, seg=7'b0001110, dp=0; slot 2: an=1011, seg=7'b0100100.
REQ-032 Run 200 cycles -> frame_start period is exactly 64 cycles; idx sequence is 0,1,2,3,0.
REQ-033 digit_en=4'b0101 -> an[1] and an[3] are never 0; slot timing is unchanged.
REQ-034 enable dropped at cnt=9 of SHOW -> next cycle an=1111 and state is IDLE; re-enable restarts at slot 0 with frame_start.
REQ-035 digits=16'h0010, digit_en=1111, with the macro -> slots 3 and 2 give seg=7F, slot 1 gives 7'b1111001, slot 0 gives 7'b1000000; without the macro -> slot 3 gives 7'b1000000.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
// Holds the scan FSM state type, the captured-input payload and the active-low
// hex segment table ({g,f,e,d,c,b,a}, 0 = segment lit).
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Inputs captured at the start of every slot; SHOW only looks at these.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp_mask;
        logic [3:0]  digit_en;
    } hold_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // True when digit i (i>0) and every more significant digit are zero.
    function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] i);
        logic r;
        r = 1'b0;
        case (i)
            2'd1:    r = (d[15:4] == 12'h000);
            2'd2:    r = (d[15:8] == 8'h00);
            2'd3:    r = (d[15:12] == 4'h0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// seg_hex_decode: combinational hex nibble to active-low seven-segment pattern.
// Ports: nibble (4-bit hex value in), seg_c (7-bit {g,f,e,d,c,b,a}, active-low).
import seg_pkg::*;

module seg_hex_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for a 4-digit common-anode display.
// Each digit owns a slot of 2^SCAN_BITS cycles: BLANK_CYCLES anode-off guard
// cycles followed by the lit portion. Inputs are captured at each slot start.
// Ports:
//   clock, reset      single clock, asynchronous active-high reset
//   enable            scan enable; low returns to IDLE with the display dark
//   digits[15:0]      four hex nibbles, digit i = digits[4i+3:4i]
//   dp_mask[3:0]      decimal point request per digit (active-high)
//   digit_en[3:0]     per-digit enable; disabled digits keep their slot dark
//   an[3:0]           anodes, active-low, registered
//   seg[6:0]          {g,f,e,d,c,b,a}, active-low, registered
//   dp                decimal point, active-low, registered
//   frame_start       one-cycle pulse on the first BLANK cycle of digit 0
// Build option: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (not digit 0).
import seg_pkg::*;

module seg_scan_ctrl #(
    parameter int unsigned SCAN_BITS    = 17,
    parameter int unsigned BLANK_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam logic [SCAN_BITS-1:0] CNT_LAST   = '1;
    localparam logic [SCAN_BITS-1:0] BLANK_LAST = SCAN_BITS'(BLANK_CYCLES - 1);

    state_t               state, state_d;
    logic [SCAN_BITS-1:0] cnt, cnt_d;
    logic [1:0]           idx, idx_d;
    hold_t                hold, hold_d;
    logic                 enter_blank;
    logic [3:0]           an_d;
    logic [6:0]           seg_d;
    logic                 dp_d;
    logic                 frame_start_d;
    logic [3:0]           nibble;
    logic [6:0]           dec_seg;

    // Entering or staying in SHOW never changes idx or hold, so the registered
    // copies already equal their next values whenever SHOW outputs are built.
    assign nibble = hold.digits[{idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nibble (nibble),
        .seg_c  (dec_seg)
    );

    // Next state, counters, capture and next registered outputs.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        idx_d         = idx;
        hold_d        = hold;
        enter_blank   = 1'b0;
        an_d          = 4'hF;
        seg_d         = SEG_OFF;
        dp_d          = 1'b1;
        frame_start_d = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                cnt_d = cnt + SCAN_BITS'(1);
                if (cnt == BLANK_LAST) state_d = ST_SHOW;
            end
            ST_SHOW: begin
                cnt_d = cnt + SCAN_BITS'(1);
                if (cnt == CNT_LAST) begin
                    idx_d   = idx + 2'd1;
                    state_d = ST_BLANK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping enable abandons the slot from any state.
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end

        enter_blank = (state_d == ST_BLANK) && (state != ST_BLANK);
        if (enter_blank) hold_d = '{digits: digits, dp_mask: dp_mask, digit_en: digit_en};

        frame_start_d = enter_blank && (idx_d == 2'd0);

        if (state_d == ST_SHOW) begin
            an_d[idx] = ~hold.digit_en[idx];
            seg_d     = dec_seg;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (lead_zero(hold.digits, idx)) seg_d = SEG_OFF;
`endif
            dp_d      = ~hold.dp_mask[idx];
        end
    end

    // State, counters, holding register and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            hold        <= '0;
            an          <= 4'hF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            hold        <= hold_d;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= frame_start_d;
        end
    end

endmodule
